if_id_fifo: RTL and testbench

//  Instruction queue between the fetch stage and the decode stage. Captures
//  {pc, inst, delay-slot flag, exception vector} tuples produced each fetch

---
 rtl/if_id_fifo.sv | 139 +++++++++++++
 tb/tb_if_id_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// ---------------------------------------------------------------------------
// if_id_fifo
//
// Instruction queue between the fetch (IF) and decode (ID) stages. Each
// fetch cycle may deliver a {pc, inst, delay-slot flag, exception vector}
// tuple. The queue presents tuples to ID in order, first-word-fall-through,
// and soaks up ID stalls so instruction SRAM data already in flight is never
// lost. A branch mispredict or exception flushes every entry.
//
// Parameters
//   DEPTH  entry count (power of two, >= 2)
//   EXC_W  width of the exception vector carried with each instruction
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   flush_i          discard all entries (synchronous, beats push/pop)
//   in_valid_i       fetch presents a tuple this cycle
//   in_ready_o       queue can accept a tuple this cycle
//   if_pc_i, if_inst_i, if_inslot_i, if_excs_i, if_has_exc_i
//                    tuple fields from fetch
//   id_stall_i       decode cannot consume this cycle
//   id_valid_o       head entry valid
//   id_pc_o, id_inst_o, id_inslot_o, id_excs_o, id_has_exc_o
//                    head tuple fields, all zero while id_valid_o is low
//   count_o          current occupancy
//   stallreq_o       occupancy >= DEPTH-1, asks the controller to hold fetch
// ---------------------------------------------------------------------------
module if_id_fifo #(
    parameter int DEPTH = 4,
    parameter int EXC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                if_pc_i,
    input  logic [31:0]                if_inst_i,
    input  logic                       if_inslot_i,
    input  logic [EXC_W-1:0]           if_excs_i,
    input  logic                       if_has_exc_i,
    input  logic                       id_stall_i,
    output logic                       id_valid_o,
    output logic [31:0]                id_pc_o,
    output logic [31:0]                id_inst_o,
    output logic                       id_inslot_o,
    output logic [EXC_W-1:0]           id_excs_o,
    output logic                       id_has_exc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       stallreq_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 32 + 32 + 1 + EXC_W + 1;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ALMOST = (AW + 1)'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic               push;
    logic               pop;
    logic               not_empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake signals derive from registered occupancy only, so in_ready_o
    // never depends combinationally on ID. A full queue refuses new tuples
    // even if ID pops in the same cycle; the freed slot shows up next cycle.
    always_comb begin
        not_empty  = (count_q != '0);
        in_ready_o = (count_q != CNT_FULL);
        push       = in_valid_i & in_ready_o;
        pop        = not_empty & ~id_stall_i;
        wr_entry   = {if_pc_i, if_inst_i, if_inslot_i, if_excs_i, if_has_exc_i};
    end

    // Pointer and occupancy update. Flush wins over everything, dropping the
    // tuple presented alongside it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; every read is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head presentation: zero (a nop instruction) whenever the queue is empty.
    always_comb begin
        head_entry = not_empty ? mem_q[rd_ptr_q] : '0;
        {id_pc_o, id_inst_o, id_inslot_o, id_excs_o, id_has_exc_o} = head_entry;
        id_valid_o = not_empty;
        count_o    = count_q;
        // Fetch has one registered cycle in flight, so ask for a stall one
        // entry early to leave room for it.
        stallreq_o = (count_q >= CNT_ALMOST);
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// ---------------------------------------------------------------------------
// tb_if_id_fifo
//
// Self-checking bench for if_id_fifo. A queue of tuples models the FIFO's
// contents; every cycle the DUT outputs are compared with the queue head and
// size, then the queue is updated from the handshake rules.
// ---------------------------------------------------------------------------
module tb_if_id_fifo;

    localparam int DEPTH = 4;
    localparam int EXC_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             inslot;
        logic [EXC_W-1:0] excs;
        logic             has_exc;
    } tuple_t;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      if_pc_i;
    logic [31:0]      if_inst_i;
    logic             if_inslot_i;
    logic [EXC_W-1:0] if_excs_i;
    logic             if_has_exc_i;
    logic             id_stall_i;
    logic             id_valid_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_inst_o;
    logic             id_inslot_o;
    logic [EXC_W-1:0] id_excs_o;
    logic             id_has_exc_o;
    logic [CW-1:0]    count_o;
    logic             stallreq_o;

    tuple_t model_q[$];
    int     compared;
    int     mismatched;
    int     pc_seed;

    if_id_fifo #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .if_pc_i      (if_pc_i),
        .if_inst_i    (if_inst_i),
        .if_inslot_i  (if_inslot_i),
        .if_excs_i    (if_excs_i),
        .if_has_exc_i (if_has_exc_i),
        .id_stall_i   (id_stall_i),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_inslot_o  (id_inslot_o),
        .id_excs_o    (id_excs_o),
        .id_has_exc_o (id_has_exc_o),
        .count_o      (count_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model's head entry and occupancy.
    task automatic checkOutput(input string tag);
        tuple_t head;
        int     n;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : '0;
        checkVal({tag, ".valid"},    32'(id_valid_o),   32'(n != 0));
        checkVal({tag, ".pc"},       id_pc_o,           head.pc);
        checkVal({tag, ".inst"},     id_inst_o,         head.inst);
        checkVal({tag, ".inslot"},   32'(id_inslot_o),  32'(head.inslot));
        checkVal({tag, ".excs"},     32'(id_excs_o),    32'(head.excs));
        checkVal({tag, ".has_exc"},  32'(id_has_exc_o), 32'(head.has_exc));
        checkVal({tag, ".count"},    32'(count_o),      32'(n));
        checkVal({tag, ".ready"},    32'(in_ready_o),   32'(n != DEPTH));
        checkVal({tag, ".stallreq"}, 32'(stallreq_o),   32'(n >= DEPTH - 1));
    endtask

    // One clock cycle: drive inputs just after a rising edge, check at the
    // falling edge, advance the model, then move past the next rising edge.
    task automatic applyStimulus(input string tag, input logic valid,
                                 input logic stall, input logic flush,
                                 input tuple_t t);
        bit do_push;
        bit do_pop;
        in_valid_i   = valid;
        id_stall_i   = stall;
        flush_i      = flush;
        if_pc_i      = t.pc;
        if_inst_i    = t.inst;
        if_inslot_i  = t.inslot;
        if_excs_i    = t.excs;
        if_has_exc_i = t.has_exc;
        @(negedge clk);
        checkOutput(tag);
        if (flush) begin
            model_q.delete();
        end else begin
            do_push = valid && (model_q.size() != DEPTH);
            do_pop  = (model_q.size() != 0) && !stall;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic tuple_t mkTuple(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic inslot, input logic [EXC_W-1:0] excs,
                                       input logic has_exc);
        tuple_t t;
        t.pc      = pc;
        t.inst    = inst;
        t.inslot  = inslot;
        t.excs    = excs;
        t.has_exc = has_exc;
        return t;
    endfunction

    function automatic tuple_t randTuple();
        tuple_t t;
        pc_seed   = pc_seed + 4;
        t.pc      = 32'hbfc0_0000 + 32'(pc_seed);
        t.inst    = $urandom;
        t.inslot  = 1'($urandom_range(0, 1));
        t.excs    = EXC_W'($urandom);
        t.has_exc = (t.excs != '0);
        return t;
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;
        pc_seed    = 0;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        id_stall_i   = 1'b0;
        if_pc_i      = '0;
        if_inst_i    = '0;
        if_inslot_i  = 1'b0;
        if_excs_i    = '0;
        if_has_exc_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push, no stall: visible one cycle later.
        applyStimulus("boot_push", 1'b1, 1'b0, 1'b0,
                      mkTuple(32'hbfc0_0000, 32'h2408_0001, 1'b0, '0, 1'b0));
        applyStimulus("boot_head", 1'b0, 1'b0, 1'b0, '0);
        applyStimulus("boot_empty", 1'b0, 1'b0, 1'b0, '0);

        // Fill under stall; fifth tuple must be refused.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("fill", 1'b1, 1'b1, 1'b0, randTuple());
        end
        applyStimulus("full_hold", 1'b0, 1'b1, 1'b0, '0);

        // Push+pop while full: only the pop happens.
        applyStimulus("full_pushpop", 1'b1, 1'b0, 1'b0, randTuple());
        // Push+pop at DEPTH-1 keeps occupancy, pointers wrap.
        for (int i = 0; i < 6; i++) begin
            applyStimulus("wrap", 1'b1, 1'b0, 1'b0, randTuple());
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus("drain", 1'b0, 1'b0, 1'b0, '0);
        end

        // Flush with two entries and a tuple presented alongside.
        applyStimulus("pre_flush", 1'b1, 1'b1, 1'b0, randTuple());
        applyStimulus("pre_flush", 1'b1, 1'b1, 1'b0, randTuple());
        applyStimulus("flush", 1'b1, 1'b1, 1'b1,
                      mkTuple(32'hdead_beef, 32'hcafe_f00d, 1'b1, 8'hff, 1'b1));
        applyStimulus("post_flush", 1'b0, 1'b0, 1'b0, '0);

        // Exception tuple travels unchanged.
        applyStimulus("exc_push", 1'b1, 1'b0, 1'b0,
                      mkTuple(32'hbfc0_0002, 32'h0000_0000, 1'b0, 8'h02, 1'b1));
        applyStimulus("exc_head", 1'b0, 1'b1, 1'b0, '0);
        checkVal("exc_excs_direct", 32'(id_excs_o), 32'h02);
        checkVal("exc_pc_direct", id_pc_o, 32'hbfc0_0002);
        applyStimulus("exc_pop", 1'b0, 1'b0, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 29) == 0), randTuple());
        end

        // Asynchronous reset mid-stream with three entries queued.
        applyStimulus("rst_prep", 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("rst_fill", 1'b1, 1'b1, 1'b0, randTuple());
        end
        checkVal("rst_pre_count", 32'(count_o), 32'd3);
        in_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checkOutput("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("after_reset", 1'b1, 1'b0, 1'b0, randTuple());
        applyStimulus("after_reset", 1'b0, 1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
